// File: rtl/synapse_unit.sv
// -----------------------------------------------------------------------------
// synapse_unit
// Pre-synaptic front end for one soma. Incoming spike events {id, time} are
// buffered in a circular FIFO; a small FSM pops one event at a time, looks up
// the per-synapse weight in a programmable table and presents the
// (weight, spike-time) pair to the soma over a valid/ready handshake.
//
// Ports
//   clk         in   clock
//   rst         in   asynchronous active-low reset
//   kill        in   synchronous flush: empties FIFO, aborts delivery
//   spk_valid   in   incoming event valid
//   spk_id      in   synapse index of event
//   spk_time    in   time delta carried with event
//   spk_ready   out  event accepted when spk_valid && spk_ready at clk edge
//   wr_en       in   weight table write strobe
//   wr_addr     in   weight table write index (>= N_SYN ignored)
//   wr_data     in   weight value
//   out_valid   out  delivery pair valid
//   out_ready   in   soma accepts pair
//   out_weight  out  weight of delivered event
//   out_spike   out  spike time of delivered event
//   fifo_count  out  events currently buffered (0..DEPTH)
//   overflow    out  sticky: event offered while not ready (cleared by rst)
// -----------------------------------------------------------------------------
module synapse_unit #(
    parameter int N_SYN = 16,
    parameter int ID_W  = 4,
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kill,
    input  logic             spk_valid,
    input  logic [ID_W-1:0]  spk_id,
    input  logic [7:0]       spk_time,
    output logic             spk_ready,
    input  logic             wr_en,
    input  logic [ID_W-1:0]  wr_addr,
    input  logic [7:0]       wr_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_weight,
    output logic [7:0]       out_spike,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow
);

    localparam int PTR_W = CNT_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_SEND  = 2'b10
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ID_W-1:0]   r_mem_id   [DEPTH];
    logic [7:0]        r_mem_time [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    logic [7:0]        r_table [N_SYN];

    logic [ID_W-1:0]   r_lat_id;
    logic [7:0]        r_lat_time;
    logic              r_out_valid;
    logic [7:0]        r_out_weight;
    logic [7:0]        r_out_spike;
    logic              r_overflow;

    logic              w_spk_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_load_out;
    logic              w_clr_out;
    logic              w_not_empty;
    logic [7:0]        w_table_rd;

    // Acceptance depends only on kill and the registered count.
    assign w_spk_ready = !kill && (r_count < CNT_W'(DEPTH));
    assign w_push      = spk_valid && w_spk_ready;
    assign w_not_empty = (r_count != {CNT_W{1'b0}});

    // Weight lookup for the latched id; ids outside the table read as zero.
    always_comb begin
        w_table_rd = 8'd0;
        if (32'(r_lat_id) < N_SYN) begin
            w_table_rd = r_table[r_lat_id];
        end else begin
            w_table_rd = 8'd0;
        end
    end

    // FSM next-state and control strobes; kill overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load_out  = 1'b0;
        w_clr_out   = 1'b0;
        if (kill) begin
            w_state_nxt = ST_IDLE;
            w_clr_out   = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_not_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    w_load_out  = 1'b1;
                    w_state_nxt = ST_SEND;
                end
                ST_SEND: begin
                    if (out_ready) begin
                        w_clr_out = 1'b1;
                        // Back-to-back pop keeps the 2-cycle delivery cadence.
                        if (w_not_empty) begin
                            w_pop       = 1'b1;
                            w_state_nxt = ST_FETCH;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_state_nxt = ST_SEND;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_clr_out   = 1'b1;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FIFO storage: written at the write pointer on every accepted event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_id[i]   <= {ID_W{1'b0}};
                r_mem_time[i] <= 8'd0;
            end
        end else if (w_push) begin
            r_mem_id[r_wptr]   <= spk_id;
            r_mem_time[r_wptr] <= spk_time;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else if (kill) begin
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Weight table; a same-cycle FETCH sees the value before this write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_SYN; i++) begin
                r_table[i] <= 8'd0;
            end
        end else if (wr_en && (32'(wr_addr) < N_SYN)) begin
            r_table[wr_addr] <= wr_data;
        end
    end

    // Head-of-FIFO latch taken on every pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lat_id   <= {ID_W{1'b0}};
            r_lat_time <= 8'd0;
        end else if (w_pop) begin
            r_lat_id   <= r_mem_id[r_rptr];
            r_lat_time <= r_mem_time[r_rptr];
        end
    end

    // Delivery outputs: loaded in FETCH, held through SEND, valid dropped on
    // handshake or kill (payload registers simply keep their last value).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid  <= 1'b0;
            r_out_weight <= 8'd0;
            r_out_spike  <= 8'd0;
        end else if (w_load_out) begin
            r_out_valid  <= 1'b1;
            r_out_weight <= w_table_rd;
            r_out_spike  <= r_lat_time;
        end else if (w_clr_out) begin
            r_out_valid  <= 1'b0;
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (spk_valid && !w_spk_ready) begin
            r_overflow <= 1'b1;
        end
    end

    assign spk_ready  = w_spk_ready;
    assign out_valid  = r_out_valid;
    assign out_weight = r_out_weight;
    assign out_spike  = r_out_spike;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_synapse_unit.sv
// -----------------------------------------------------------------------------
// tb_synapse_unit
// Directed self-checking bench for synapse_unit. Outputs are sampled 1 time
// unit after each rising edge, where inputs are also driven.
// -----------------------------------------------------------------------------
module tb_synapse_unit;

    logic       clk;
    logic       rst;
    logic       kill;
    logic       spk_valid;
    logic [3:0] spk_id;
    logic [7:0] spk_time;
    logic       spk_ready;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_weight;
    logic [7:0] out_spike;
    logic [3:0] fifo_count;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;

    synapse_unit #(.N_SYN(16), .ID_W(4), .DEPTH(8), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .kill       (kill),
        .spk_valid  (spk_valid),
        .spk_id     (spk_id),
        .spk_time   (spk_time),
        .spk_ready  (spk_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_weight (out_weight),
        .out_spike  (out_spike),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] id, input logic [7:0] t);
        spk_valid = 1'b1;
        spk_id    = id;
        spk_time  = t;
        step();
        spk_valid = 1'b0;
    endtask

    task automatic wr_weight(input logic [3:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int c = 0; c < budget; c++) begin
            if (out_valid) break;
            step();
        end
        check_eq(tag, 32'(out_valid), 32'd1);
    endtask

    // Programmed weight image: 0x40+id, except id3=0x20 and id5=0x10.
    function automatic logic [7:0] exp_w(input logic [3:0] id);
        if (id == 4'd3) return 8'h20;
        else if (id == 4'd5) return 8'h10;
        else return 8'h40 + 8'(id);
    endfunction

    logic [3:0]  q_id   [9];
    logic [7:0]  q_time [9];
    logic [15:0] rdy_pat;
    int          ndel;
    int          last_c;
    logic        prev_hold;
    logic [7:0]  prev_w;
    logic [7:0]  prev_s;

    initial begin
        rst = 1'b0; kill = 1'b0; spk_valid = 1'b0; spk_id = 4'd0; spk_time = 8'd0;
        wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'd0; out_ready = 1'b1;
        #12;
        // Reset state
        check_eq("rst_valid",  32'(out_valid),  32'd0);
        check_eq("rst_weight", 32'(out_weight), 32'd0);
        check_eq("rst_spike",  32'(out_spike),  32'd0);
        check_eq("rst_count",  32'(fifo_count), 32'd0);
        check_eq("rst_ovf",    32'(overflow),   32'd0);
        check_eq("rst_ready",  32'(spk_ready),  32'd1);
        rst = 1'b1;
        step();

        for (int i = 0; i < 16; i++) wr_weight(4'(i), 8'h40 + 8'(i));
        wr_weight(4'd3, 8'h20);
        wr_weight(4'd5, 8'h10);

        // Single event latency: accept at t, valid after t+2, gone after t+3
        push(4'd3, 8'd5);
        check_eq("lat_t0_valid", 32'(out_valid), 32'd0);
        check_eq("lat_t0_count", 32'(fifo_count), 32'd1);
        step();
        check_eq("lat_t1_valid", 32'(out_valid), 32'd0);
        step();
        check_eq("lat_t2_valid",  32'(out_valid),  32'd1);
        check_eq("lat_t2_weight", 32'(out_weight), 32'h20);
        check_eq("lat_t2_spike",  32'(out_spike),  32'd5);
        step();
        check_eq("lat_t3_valid", 32'(out_valid), 32'd0);
        check_eq("lat_ovf",      32'(overflow),  32'd0);

        // Fill while soma is stalled: one event parked in SEND, then 9 offered
        out_ready = 1'b0;
        push(4'd2, 8'h33);
        wait_valid("stall_wait", 10);
        q_id[0] = 4'd2; q_time[0] = 8'h33;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) begin
                check_eq("full_ready", 32'(spk_ready), 32'd0);
                check_eq("full_ovf_pre", 32'(overflow), 32'd0);
            end
            if (i < 8) begin
                q_id[i+1] = 4'(i); q_time[i+1] = 8'(10 + i);
            end
            push(4'(i), 8'(10 + i));
        end
        check_eq("full_count", 32'(fifo_count), 32'd8);
        check_eq("full_ovf",   32'(overflow),   32'd1);
        check_eq("full_hold",  32'(out_spike),  32'h33);

        // Drain: 9 deliveries in order, spaced 2 cycles apart
        out_ready = 1'b1;
        ndel = 0; last_c = 0;
        for (int c = 0; c < 40 && ndel < 9; c++) begin
            if (out_valid) begin
                check_eq($sformatf("drain%0d_weight", ndel), 32'(out_weight), 32'(exp_w(q_id[ndel])));
                check_eq($sformatf("drain%0d_spike", ndel),  32'(out_spike),  32'(q_time[ndel]));
                if (ndel > 0) check_eq($sformatf("drain%0d_gap", ndel), 32'(c - last_c), 32'd2);
                last_c = c;
                ndel++;
            end
            step();
        end
        check_eq("drain_total", 32'(ndel), 32'd9);
        check_eq("drain_count", 32'(fifo_count), 32'd0);

        // Toggling out_ready: payload stable until handshake, each event once
        out_ready = 1'b0;
        q_id[0] = 4'd6; q_time[0] = 8'h60;
        q_id[1] = 4'd7; q_time[1] = 8'h61;
        q_id[2] = 4'd4; q_time[2] = 8'h62;
        for (int i = 0; i < 3; i++) push(q_id[i], q_time[i]);
        rdy_pat = 16'b0110_0010_1001_1000;
        ndel = 0; prev_hold = 1'b0; prev_w = 8'd0; prev_s = 8'd0;
        for (int c = 0; c < 60 && ndel < 3; c++) begin
            out_ready = rdy_pat[c % 16];
            if (prev_hold) begin
                check_eq("tog_hold_valid",  32'(out_valid),  32'd1);
                check_eq("tog_hold_weight", 32'(out_weight), 32'(prev_w));
                check_eq("tog_hold_spike",  32'(out_spike),  32'(prev_s));
            end
            if (out_valid && out_ready) begin
                check_eq($sformatf("tog%0d_weight", ndel), 32'(out_weight), 32'(exp_w(q_id[ndel])));
                check_eq($sformatf("tog%0d_spike", ndel),  32'(out_spike),  32'(q_time[ndel]));
                ndel++;
                prev_hold = 1'b0;
            end else if (out_valid) begin
                prev_hold = 1'b1; prev_w = out_weight; prev_s = out_spike;
            end else begin
                prev_hold = 1'b0;
            end
            step();
        end
        check_eq("tog_total", 32'(ndel), 32'd3);
        check_eq("tog_valid_end", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        step();

        // Write during FETCH of the same entry: old value delivered
        push(4'd5, 8'h55);
        step();
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h7F;
        step();
        wr_en = 1'b0;
        check_eq("wrf_valid",  32'(out_valid),  32'd1);
        check_eq("wrf_old",    32'(out_weight), 32'h10);
        check_eq("wrf_spike",  32'(out_spike),  32'h55);
        step();
        push(4'd5, 8'h56);
        step();
        step();
        check_eq("wrf_new_valid", 32'(out_valid),  32'd1);
        check_eq("wrf_new",       32'(out_weight), 32'h7F);
        step();

        // Kill mid-SEND with 4 events buffered
        out_ready = 1'b0;
        for (int i = 1; i < 5; i++) push(4'(i), 8'(i));
        check_eq("kill_pre_valid", 32'(out_valid),  32'd1);
        check_eq("kill_pre_count", 32'(fifo_count), 32'd3);
        kill = 1'b1;
        #1;
        check_eq("kill_ready", 32'(spk_ready), 32'd0);
        step();
        kill = 1'b0;
        check_eq("kill_valid", 32'(out_valid),  32'd0);
        check_eq("kill_count", 32'(fifo_count), 32'd0);
        check_eq("kill_ovf",   32'(overflow),   32'd1);
        step();
        step();
        check_eq("kill_stay_idle", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        push(4'd3, 8'h03);
        wait_valid("kill_wt_wait", 5);
        check_eq("kill_wt_keep", 32'(out_weight), 32'h20);
        step();

        // Asynchronous reset mid-delivery
        out_ready = 1'b0;
        push(4'd4, 8'h99);
        wait_valid("arst_wait", 5);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_valid",  32'(out_valid),  32'd0);
        check_eq("arst_weight", 32'(out_weight), 32'd0);
        check_eq("arst_spike",  32'(out_spike),  32'd0);
        check_eq("arst_count",  32'(fifo_count), 32'd0);
        check_eq("arst_ovf",    32'(overflow),   32'd0);
        #1;
        rst = 1'b1;
        step();
        check_eq("arst_ready", 32'(spk_ready), 32'd1);
        push(4'd3, 8'h44);
        wait_valid("arst_tbl_wait", 5);
        check_eq("arst_tbl_zero", 32'(out_weight), 32'd0);
        check_eq("arst_tbl_spk",  32'(out_spike),  32'h44);
        out_ready = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
